// File: rtl/tick_gen_bank.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_bank
// Purpose  : Bank of NUM_CH independent programmable timebase channels for the
//            100 MHz fabric. Each channel produces a single-cycle tick strobe
//            (for use as a clock enable) and a square-wave / busy level, in
//            either free-run or one-shot mode. No derived clocks are made.
// Ports    : clk_100MHz   - system clock, rising edge
//            reset        - synchronous, active-high
//            en           - per-channel run enable (free-run mode)
//            start        - per-channel trigger (one-shot mode)
//            sync_clr     - clears every channel counter together
//            cfg_we       - configuration write strobe
//            cfg_ch       - channel addressed by the write
//            cfg_div      - new period in cycles (0 and 1 are stored as 2)
//            cfg_oneshot  - new mode: 0 free-run, 1 one-shot
//            tick_o       - one-cycle strobe per period / per shot
//            sq_o         - square wave (free-run) or busy level (one-shot)
//            busy_o       - one-shot in progress
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 10_000_000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] start,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o,
  output logic [NUM_CH-1:0] busy_o
);

  localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  // Periods below 2 cannot produce a distinct tick, so they are clamped.
  logic [CNT_W-1:0] w_div_ld;
  assign w_div_ld = (cfg_div < C_MIN_DIV) ? C_MIN_DIV : cfg_div;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] r_div;
      logic [CNT_W-1:0] r_cnt;
      logic             r_oneshot;
      logic             r_busy;
      logic             r_tick;
      logic             r_sq;
      logic             w_wr;
      logic             w_last;

      // An out-of-range cfg_ch matches no channel, so such writes are dropped.
      assign w_wr   = cfg_we && (cfg_ch == CH_W'(c));
      assign w_last = (r_cnt == (r_div - C_ONE));

      always_ff @(posedge clk_100MHz) begin
        if (reset) begin
          r_div     <= C_DEF_DIV;
          r_oneshot <= 1'b0;
          r_cnt     <= '0;
          r_busy    <= 1'b0;
          r_tick    <= 1'b0;
          r_sq      <= 1'b0;
        end else if (w_wr) begin
          // New div takes effect from cnt=0; any run in progress is abandoned.
          r_div     <= w_div_ld;
          r_oneshot <= cfg_oneshot;
          r_cnt     <= '0;
          r_busy    <= 1'b0;
          r_tick    <= 1'b0;
          r_sq      <= 1'b0;
        end else if (sync_clr) begin
          r_cnt     <= '0;
          r_busy    <= 1'b0;
          r_tick    <= 1'b0;
          r_sq      <= 1'b0;
        end else if (!r_oneshot) begin
          r_busy <= 1'b0;
          if (en[c]) begin
            r_cnt  <= w_last ? '0 : r_cnt + C_ONE;
            r_tick <= w_last;
            r_sq   <= (r_cnt >= (r_div >> 1));
          end else begin
            // Dropping en discards the partial period.
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_sq   <= 1'b0;
          end
        end else if (r_busy) begin
          // start is ignored while a shot is running: no retrigger.
          if (w_last) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_busy <= 1'b0;
            r_sq   <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + C_ONE;
            r_tick <= 1'b0;
            r_sq   <= 1'b1;
          end
        end else begin
          r_tick <= 1'b0;
          r_cnt  <= '0;
          r_busy <= start[c];
          r_sq   <= start[c];
        end
      end

      assign tick_o[c] = r_tick;
      assign sq_o[c]   = r_sq;
      assign busy_o[c] = r_busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tick_gen_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_gen_bank
// Purpose  : Self-checking bench for tick_gen_bank (3 channels, default div 10).
//            A period-arithmetic reference model is compared against the DUT
//            every cycle; directed steps add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_gen_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int DEF    = 10;

  logic              clk_100MHz = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] en = '0;
  logic [NUM_CH-1:0] start = '0;
  logic              sync_clr = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_oneshot = 1'b0;
  logic [NUM_CH-1:0] tick_o, sq_o, busy_o;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  tick_gen_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .en         (en),
    .start      (start),
    .sync_clr   (sync_clr),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_oneshot(cfg_oneshot),
    .tick_o     (tick_o),
    .sq_o       (sq_o),
    .busy_o     (busy_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Reference model. Free-run: k = enabled edges since the last restart; a tick
  // follows every edge where k is a multiple of div and the wave is high in the
  // second half of each period. One-shot: age counts edges since the start was
  // accepted; the shot ends with a tick when age reaches div.
  int m_div [NUM_CH];
  bit m_one [NUM_CH];
  int m_k   [NUM_CH];
  bit m_busy[NUM_CH];
  logic [NUM_CH-1:0] e_tick, e_sq, e_busy;

  always @(posedge clk_100MHz) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        m_div[c] = DEF; m_one[c] = 0; m_k[c] = 0; m_busy[c] = 0;
        e_tick[c] = 0; e_sq[c] = 0;
      end else if (cfg_we && int'(cfg_ch) == c) begin
        m_div[c] = (cfg_div < 2) ? 2 : int'(cfg_div);
        m_one[c] = cfg_oneshot; m_k[c] = 0; m_busy[c] = 0;
        e_tick[c] = 0; e_sq[c] = 0;
      end else if (sync_clr) begin
        m_k[c] = 0; m_busy[c] = 0; e_tick[c] = 0; e_sq[c] = 0;
      end else if (!m_one[c]) begin
        if (en[c]) begin
          m_k[c]++;
          e_tick[c] = (m_k[c] % m_div[c]) == 0;
          e_sq[c]   = ((m_k[c] - 1) % m_div[c]) >= (m_div[c] / 2);
        end else begin
          m_k[c] = 0; e_tick[c] = 0; e_sq[c] = 0;
        end
      end else begin
        e_tick[c] = 0;
        if (m_busy[c]) begin
          m_k[c]++;
          if (m_k[c] == m_div[c]) begin e_tick[c] = 1; m_busy[c] = 0; end
        end else if (start[c]) begin
          m_busy[c] = 1; m_k[c] = 0;
        end
        e_sq[c] = m_busy[c];
      end
      e_busy[c] = m_busy[c];
    end
  end

  always @(negedge clk_100MHz) begin
    if (chk_on) begin
      checks += 3;
      if (tick_o !== e_tick) begin
        errors++; $display("FAIL model tick_o t=%0t: got %b expected %b", $time, tick_o, e_tick);
      end
      if (sq_o !== e_sq) begin
        errors++; $display("FAIL model sq_o t=%0t: got %b expected %b", $time, sq_o, e_sq);
      end
      if (busy_o !== e_busy) begin
        errors++; $display("FAIL model busy_o t=%0t: got %b expected %b", $time, busy_o, e_busy);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_100MHz); #1; end
  endtask

  task automatic hand(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic cfg(input int ch, input int dv, input bit one);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_div = CNT_W'(dv); cfg_oneshot = one;
    cyc(1);
    cfg_we = 0;
  endtask

  initial begin
    cyc(1);
    chk_on = 1;
    cyc(2);
    hand("reset_tick", 8'(tick_o), 8'd0);
    hand("reset_sq",   8'(sq_o),   8'd0);
    hand("reset_busy", 8'(busy_o), 8'd0);

    // Free-run ch0 at default div 10.
    reset = 0; en = 3'b001;
    cyc(5);  hand("fr_sq_low_e5",   8'(sq_o[0]), 8'd0);
    cyc(1);  hand("fr_sq_high_e6",  8'(sq_o[0]), 8'd1);
    cyc(3);  hand("fr_tick_e9",     8'(tick_o[0]), 8'd0);
    cyc(1);  hand("fr_tick_e10",    8'(tick_o[0]), 8'd1);
             hand("fr_ch12_idle",   8'({tick_o[2:1], sq_o[2:1]}), 8'd0);
    cyc(10); hand("fr_tick_e20",    8'(tick_o[0]), 8'd1);
    cyc(1);  hand("fr_sq_e21",      8'(sq_o[0]), 8'd0);

    // ch1 div 3 while ch0 keeps running.
    en = 3'b011; cfg(1, 3, 0);
    hand("wr_clears_tick", 8'(tick_o[1]), 8'd0);
    cyc(2);  hand("d3_tick_e2", 8'(tick_o[1]), 8'd0);
    cyc(1);  hand("d3_tick_e3", 8'(tick_o[1]), 8'd1);
    cyc(3);  hand("d3_tick_e6", 8'(tick_o[1]), 8'd1);

    // div 0 and 1 behave as 2.
    cfg(1, 0, 0);
    cyc(1);  hand("d0_tick_e1", 8'(tick_o[1]), 8'd0);
    cyc(1);  hand("d0_tick_e2", 8'(tick_o[1]), 8'd1);
    cyc(4);
    cfg(1, 1, 0);
    cyc(2);  hand("d1_tick_e2", 8'(tick_o[1]), 8'd1);
    cyc(4);

    // Out-of-range channel write is ignored; en drop discards the period.
    cfg(3, 5, 1);
    cyc(4);
    en = 3'b010; cyc(3);
    en = 3'b011; cyc(12);

    // One-shot ch0 div 4; en is ignored in this mode.
    cfg(0, 4, 1);
    start = 3'b001; cyc(1); start = 0;
    hand("os_busy_e0", 8'({busy_o[0], sq_o[0], tick_o[0]}), 8'b110);
    cyc(1); start = 3'b001; cyc(1); start = 0;
    hand("os_busy_e2", 8'(busy_o[0]), 8'd1);
    cyc(1);
    cyc(1);  hand("os_end_e4", 8'({busy_o[0], tick_o[0]}), 8'b01);
    start = 3'b001; cyc(1); start = 0;
    hand("os_restart", 8'({busy_o[0], tick_o[0]}), 8'b10);
    cyc(4);  hand("os_2nd_tick", 8'(tick_o[0]), 8'd1);
    cyc(3);  hand("os_no_extra", 8'({busy_o[0], tick_o[0]}), 8'd0);
    start = 3'b001; sync_clr = 1; cyc(1); start = 0; sync_clr = 0;
    hand("os_start_drop", 8'(busy_o[0]), 8'd0);

    // Phase alignment with sync_clr.
    cfg(0, 6, 0);
    cfg(1, 4, 0);
    cyc(7);
    sync_clr = 1; cyc(1); sync_clr = 0;
    hand("sc_clear", 8'(tick_o), 8'd0);
    cyc(3);  hand("sc_ch1_e3", 8'(tick_o[1]), 8'd0);
    cyc(1);  hand("sc_ch1_e4", 8'(tick_o[1]), 8'd1);
    cyc(2);  hand("sc_ch0_e6", 8'(tick_o[0]), 8'd1);
    cyc(6);  hand("sc_both_e12", 8'(tick_o[1:0]), 8'b11);

    // Reset mid-period and mid-shot.
    cfg(2, 5, 1);
    start = 3'b100; cyc(1); start = 0;
    cyc(2);
    reset = 1; cyc(1);
    hand("rst_mid", 8'({tick_o, sq_o, busy_o}), 8'd0);
    reset = 0;
    cyc(9);  hand("rst_tick_e9",  8'(tick_o), 8'd0);
    cyc(1);  hand("rst_tick_e10", 8'(tick_o), 8'b011);
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tick_gen_bank.md
# tick_gen_bank

Multi-channel programmable timebase generator for the 100 MHz fabric clock domain. It replaces single-purpose fixed-frequency dividers with NUM_CH independent channels. Each channel has a runtime-loadable period, a free-run or one-shot mode, a single-cycle tick strobe and a square-wave level. Downstream counters, display multiplexers and debouncers consume tick_o as a clock enable. No derived clocks are generated.

## Interface

Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 27, counter/divisor width in bits
- DEFAULT_DIV, 10_000_000, period in cycles loaded into every channel at reset (10 Hz tick at 100 MHz)

Ports:
- clk_100MHz  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- en  in  NUM_CH  per-channel run enable, free-run mode only
- start  in  NUM_CH  per-channel one-shot trigger, one-shot mode only
- sync_clr  in  1  clears all channel counters together (phase alignment)
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel of write
- cfg_div  in  CNT_W  new period in cycles
- cfg_oneshot  in  1  new mode: 0 free-run, 1 one-shot
- tick_o  out  NUM_CH  one-cycle strobe per period / per shot
- sq_o  out  NUM_CH  square wave (free-run) or busy level (one-shot)
- busy_o  out  NUM_CH  one-shot in progress

## Operation

Per-channel state: div, mode, cnt, busy.
- Reset: div=DEFAULT_DIV, mode=free-run, cnt=0. All outputs are 0.
- Config write: cfg_we=1 with cfg_ch<NUM_CH.
  - Loads div from cfg_div and mode from cfg_oneshot.
  - cfg_div of 0 or 1 is stored as 2.
  - Clears cnt and busy. tick_o for that channel is 0 the next cycle.
  - cfg_ch≥NUM_CH: the write is ignored.
- Free-run, en=1 on each edge:
  - cnt <= (cnt==div-1) ? 0 : cnt+1
  - tick_o <= (cnt==div-1)
  - sq_o <= (cnt ≥ div>>1)
- Free-run, en=0: cnt <= 0, tick_o <= 0, sq_o <= 0.
- One-shot, idle: start=1 sets busy and cnt=0. en is ignored in this mode.
- One-shot, busy:
  - cnt increments each cycle.
  - At cnt==div-1: tick_o <= 1, busy <= 0, cnt <= 0.
  - start while busy is ignored (no retrigger).
- One-shot outputs: sq_o mirrors busy_o.
- Divisor written while a channel is running: the new div applies from cnt=0, because the write clears cnt.
- sync_clr=1: for every channel, cnt <= 0, busy <= 0, tick_o <= 0, sq_o <= 0. div and mode are kept.
- Priority per channel: reset > config write > sync_clr > start/en counting.
  - start asserted in the same cycle as a config write or sync_clr is dropped.

## Timing

- All outputs are registered and glitch-free.
- tick_o reflects the counter state of the previous cycle.
- Free-run from cnt=0: en is first sampled high at edge 1. The first tick_o is high after edge div, then every div cycles.
  - tick_o is high exactly 1 cycle per period.
  - sq_o is low for floor(div/2) cycles, then high for ceil(div/2) cycles.
- Free-run with div=2: tick_o is high every second cycle and sq_o alternates every cycle.
- One-shot: start is sampled at edge 0.
  - busy_o is high from edge 1 through edge div.
  - tick_o is high for the cycle following edge div, coincident with busy_o falling.
  - A new start is accepted at edge div+1 at the earliest.
- en dropping mid-period: the period is discarded. Re-enable restarts a full period.
- Counter never exceeds div-1, so no wrap beyond 2^CNT_W. Values of cfg_div wider than CNT_W are unrepresentable by construction.

## Test plan

- DEFAULT_DIV=10, NUM_CH=2, en=2'b01 after reset -> tick_o[0] high on edges 10, 20, 30; sq_o[0] pattern 0×5, 1×5; channel 1 outputs stay 0.
- Write ch1 div=3 while ch0 runs at div=10 -> ch1 ticks every 3 cycles starting 3 edges after en; ch0 period is undisturbed.
- Write cfg_div=0, then cfg_div=1 -> both behave as div=2, ticking every 2 cycles.
- ch0 one-shot div=4, start pulse -> busy_o high for 4 cycles, single tick_o at the end; a start while busy produces no extra tick; a start one cycle after completion produces a second shot.
- Two free-run channels with div=6 and div=4 and arbitrary phase, then sync_clr pulse -> both produce their first tick 6 and 4 edges after sync_clr respectively, and tick together every 12 cycles.
- reset asserted mid-period and mid-shot -> the next cycle has all outputs 0, div=DEFAULT_DIV and mode free-run; counting resumes per the free-run rule once reset is released.
